// File: rtl/bcd_display_mux.sv
// Multiplexed 7-segment driver: snapshots packed BCD digits on load and scans them
// one per slot onto a shared segment bus, with leading-zero blanking and a non-BCD flag.
module bcd_display_mux #(
   parameter int N_DIGITS       = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1,
   parameter int BLANK_LEADING  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   an,
   output logic                  invalid
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
   localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
   localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_INV}};

   logic [N_DIGITS-1:0][3:0] snap;
   logic [N_DIGITS-1:0]      dps;
   logic [CW-1:0]            cnt;
   logic [IW-1:0]            idx;
   logic                     tick;
   logic [N_DIGITS-1:0]      blank_vec;
   logic [N_DIGITS-1:0]      onehot;
   logic                     bad;
   logic                     lz;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h79;
      endcase
   endfunction

   assign tick   = (cnt == CW'(SCAN_DIV-1));
   assign onehot = N_DIGITS'(1) << idx;

   // Walk from the most significant digit down; a digit is blank while every
   // digit at or above it is zero. Digit 0 always shows.
   always_comb begin
      lz        = 1'b1;
      blank_vec = '0;
      bad       = 1'b0;
      for (int k = N_DIGITS-1; k >= 0; k--) begin
         lz = lz & (snap[k] == 4'd0);
         if (BLANK_LEADING != 0 && k != 0) blank_vec[k] = lz;
         bad = bad | (snap[k] > 4'd9);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap    <= '0;
         dps     <= '0;
         cnt     <= '0;
         idx     <= '0;
         an      <= AN_OFF;
         seg     <= {7{SEG_INV}};
         dp      <= SEG_INV;
         invalid <= 1'b0;
      end else begin
         if (load) begin
            snap <= bcd_in;
            dps  <= dp_in;
         end
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= (idx == IW'(N_DIGITS-1)) ? '0 : idx + 1'b1;
         // The tick edge drops all anodes for one cycle so the segment bus can
         // settle on the next digit without ghosting.
         an      <= tick ? AN_OFF : (onehot ^ AN_OFF);
         seg     <= (blank_vec[idx] ? 7'h00 : seg_decode(snap[idx])) ^ {7{SEG_INV}};
         dp      <= dps[idx] ^ SEG_INV;
         invalid <= bad;
      end
   end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomized self-checking bench for bcd_display_mux against an edge-counting reference model.
module tb_bcd_display_mux;
   localparam int N  = 4;
   localparam int SD = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         load;
   logic [15:0]  bcd_in;
   logic [3:0]   dp_in;
   logic [6:0]   seg;
   logic         dp;
   logic [3:0]   an;
   logic         invalid;

   int n_chk  = 0;
   int n_fail = 0;

   bcd_display_mux #(.N_DIGITS(N), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1),
                     .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)) dut (
      .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
      .seg(seg), .dp(dp), .an(an), .invalid(invalid));

   always #5 clk = ~clk;

   // Active-high glyphs indexed by digit value; values above 9 show 'E'.
   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

   // Reference: slot position derived purely from the number of edges since reset.
   int          edges;
   logic [15:0] m_bcd;
   logic [3:0]  m_dp;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp, exp_inv;

   always @(posedge clk or posedge rst) begin
      int c, d;
      logic blank;
      if (rst) begin
         edges = 0; m_bcd = 16'h0; m_dp = 4'h0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_inv = 1'b0;
      end else begin
         c = edges % SD;
         d = (edges / SD) % N;
         exp_an  = (c == SD-1) ? 4'hF : ~(4'b0001 << d);
         blank   = (d > 0) && ((m_bcd >> (4*d)) == 16'h0);
         exp_seg = blank ? 7'h7F : ~glyph[m_bcd[4*d +: 4]];
         exp_dp  = ~m_dp[d];
         exp_inv = 1'b0;
         for (int k = 0; k < N; k++) if (m_bcd[4*k +: 4] > 4'd9) exp_inv = 1'b1;
         if (load) begin m_bcd = bcd_in; m_dp = dp_in; end
         edges++;
      end
   end

   task automatic test_reset();
      rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0;
      #3;
      n_chk++;
      if ({an, seg, dp, invalid} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state got an=%h seg=%h dp=%b inv=%b want an=f seg=7f dp=1 inv=0", an, seg, dp, invalid);
      end
      @(negedge clk); @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (an !== 4'hE || seg !== 7'h40) begin
         n_fail++;
         $display("FAIL first_edge got an=%h seg=%h want an=e seg=40", an, seg);
      end
      for (int i = 0; i < 2*N*SD; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
            n_fail++;
            $display("FAIL idle_scan cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
         end
      end
   endtask

   task automatic test_pattern(input logic [15:0] v, input logic [3:0] d, input string nm);
      @(negedge clk); load = 1'b1; bcd_in = v; dp_in = d;
      @(negedge clk); load = 1'b0; bcd_in = $urandom; dp_in = $urandom;
      for (int i = 0; i < 2*N*SD; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
            n_fail++;
            $display("FAIL %s cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", nm, i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
         end
         if (v == 16'h1234 && an == 4'b0111) begin
            n_chk++;
            if (seg !== 7'h79) begin
               n_fail++;
               $display("FAIL pat1234_digit3 got seg=%h want 79", seg);
            end
         end
         if (v == 16'h0050 && an == 4'b1011) begin
            n_chk++;
            if (seg !== 7'h7F || dp !== 1'b0) begin
               n_fail++;
               $display("FAIL blank_dp_digit2 got seg=%h dp=%b want 7f/0", seg, dp);
            end
         end
      end
   endtask

   task automatic test_invalid();
      @(negedge clk); load = 1'b1; bcd_in = 16'h00A1;
      @(negedge clk); load = 1'b0;
      n_chk++;
      if (invalid !== 1'b0) begin n_fail++; $display("FAIL inv_early got %b want 0", invalid); end
      @(negedge clk);
      n_chk++;
      if (invalid !== 1'b1) begin n_fail++; $display("FAIL inv_set got %b want 1", invalid); end
      load = 1'b1; bcd_in = 16'h0001;
      @(negedge clk); load = 1'b0;
      @(negedge clk);
      n_chk++;
      if (invalid !== 1'b0) begin n_fail++; $display("FAIL inv_clear got %b want 0", invalid); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         load = ($urandom_range(0, 5) == 0);
         for (int k = 0; k < N; k++) begin
            int r;
            r = $urandom_range(0, 12);
            bcd_in[4*k +: 4] = (r > 9) ? 4'($urandom_range(10, 15)) : (r < 4 ? 4'd0 : 4'(r));
         end
         dp_in = $urandom;
         @(posedge clk); #1;
         n_chk++;
         if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
            n_fail++;
            $display("FAIL random cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
         end
      end
      @(negedge clk); load = 1'b0;
   endtask

   task automatic test_mid_reset();
      int guard = 0;
      @(negedge clk); load = 1'b1; bcd_in = 16'hB000;
      @(negedge clk); load = 1'b0;
      while (exp_an !== 4'b1011 && guard < 100) begin @(posedge clk); #1; guard++; end
      n_chk++;
      if (guard >= 100) begin n_fail++; $display("FAIL mid_reset_wait got timeout want slot 2"); end
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({an, seg, invalid} !== {4'hF, 7'h7F, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset got an=%h seg=%h inv=%b want f/7f/0", an, seg, invalid);
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 2*N*SD; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
            n_fail++;
            $display("FAIL post_reset cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
         end
         if (i == SD-1 || i == SD) begin
            n_chk++;
            if (an !== ((i == SD-1) ? 4'hF : 4'hD)) begin
               n_fail++;
               $display("FAIL restart_slot cyc %0d got an=%h want %h", i, an, (i == SD-1) ? 4'hF : 4'hD);
            end
         end
      end
   endtask

   task automatic test_load_on_tick();
      int guard = 0;
      for (int rep = 0; rep < 3; rep++) begin
         @(negedge clk);
         while ((edges % SD) != SD-1 && guard < 100) begin @(negedge clk); guard++; end
         load = 1'b1; bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         dp_in = $urandom;
         @(negedge clk); load = 1'b0;
         for (int i = 0; i < SD+2; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({an, seg, dp, invalid} !== {exp_an, exp_seg, exp_dp, exp_inv}) begin
               n_fail++;
               $display("FAIL load_on_tick rep %0d cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", rep, i, an, seg, dp, invalid, exp_an, exp_seg, exp_dp, exp_inv);
            end
         end
      end
      n_chk++;
      if (guard >= 100) begin n_fail++; $display("FAIL tick_wait got timeout want tick"); end
   endtask

   initial begin
      test_reset();
      test_pattern(16'h1234, 4'b0000, "pat1234");
      test_pattern(16'h0050, 4'b0100, "pat0050");
      test_pattern(16'h0000, 4'b1111, "pat0000");
      test_pattern(16'h9876, 4'b0001, "pat9876");
      test_invalid();
      test_random();
      test_mid_reset();
      test_load_on_tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
